sram_controller: RTL and testbench
==================================

# sram_controller

Data-memory responder for the MEM stage of the five-stage ARM pipeline. It accepts one 32-bit read or write request at a time and performs it as two 16-bit accesses on an external asynchronous SRAM. While a request is in flight it drives READY low, and the top level uses this to freeze IF, ID, EX and the pipeline registers. It is the answering end of the MEM stage's memory request and the source of the pipeline freeze signal.

## Interface
- ACCESS_CYCLES, 2: cycles each 16-bit half-access is held on the SRAM bus (legal range 1..15).
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- CLK  in  1  pipeline clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- RD_EN  in  1  read request from the MEM stage; held until READY.
- WR_EN  in  1  write request from the MEM stage; held until READY.
- ADDRESS  in  32  byte address of the request.
- WRITE_DATA  in  32  store data.
- READ_DATA  out  32  load data; valid in the DONE cycle and held until the next read completes.
- READY  out  1  high when no request is pending or in the DONE cycle; freeze = ~READY.
- SRAM_ADDR  out  18  halfword address.
- SRAM_DQ_OUT  out  16  write data to the SRAM.
- SRAM_DQ_IN  in  16  read data from the SRAM.
- SRAM_DQ_OE  out  1  data-bus drive enable (1 = controller drives).
- SRAM_WE_N  out  1  active-low write strobe.

## Operation
- Word index W = (ADDRESS − BASE_ADDR) mod 2^32, bits [18:2] (17 bits). ADDRESS[1:0] is ignored.
- SRAM address: low half = {W, 1'b0}; high half = {W, 1'b1}.
- States:
  - IDLE → LOW when RD_EN or WR_EN is sampled high.
  - LOW runs for ACCESS_CYCLES cycles → HIGH.
  - HIGH runs for ACCESS_CYCLES cycles → DONE.
  - DONE → IDLE unconditionally.
- A 4-bit phase counter counts within LOW and HIGH.
- Operation type and address are latched on IDLE→LOW. Request inputs are ignored after that until the controller is back in IDLE.
- Write (WR_EN=1, including when RD_EN is also 1):
  - LOW: SRAM_DQ_OUT = WRITE_DATA[15:0].
  - HIGH: SRAM_DQ_OUT = WRITE_DATA[31:16].
  - SRAM_DQ_OE=1 and SRAM_WE_N=0 for every LOW/HIGH cycle.
  - WRITE_DATA is latched at the start.
  - READ_DATA is unchanged.
- Read:
  - SRAM_WE_N=1 and SRAM_DQ_OE=0 throughout.
  - SRAM_DQ_IN is captured on the last cycle of LOW into READ_DATA[15:0] and on the last cycle of HIGH into READ_DATA[31:16].
  - READ_DATA is updated as one 32-bit value on entry to DONE.
- In IDLE and DONE: SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR holds its last value.
- If the request drops mid-transaction, the access still completes and READY stays low until DONE.

## Timing
- Reset values: state=IDLE, READ_DATA=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, SRAM_DQ_OE=0, SRAM_WE_N=1. READY=1 while no request is present.
- READY is combinational: (IDLE & ~RD_EN & ~WR_EN) | DONE.
- A request first seen in IDLE at cycle 0 produces:
  - READY low in cycles 0 .. 2·ACCESS_CYCLES.
  - READY high in cycle 2·ACCESS_CYCLES+1 (DONE).
  - Total latency 2·ACCESS_CYCLES+2 cycles; 6 cycles at the default.
- SRAM outputs are registered: they change on the edge that enters LOW or HIGH and are stable for the whole phase.
- Back-to-back requests: the request in the cycle after DONE is taken from IDLE. There is one IDLE cycle between transactions, with READY low.
- RST asserted mid-transaction: immediate return to the reset values. A partial write may remain in the SRAM, and READ_DATA is not updated.

## Test plan
- Reset: hold RST=0 with RD_EN=1 → READY=0 is not required; check all outputs equal their reset values. Release → IDLE, and with no request READY=1.
- Write ADDRESS=1024, WRITE_DATA=0xDEADBEEF at default parameters:
  - Cycles 1–2: SRAM_ADDR=0, DQ_OUT=0xBEEF, WE_N=0.
  - Cycles 3–4: SRAM_ADDR=1, DQ_OUT=0xDEAD.
  - READY low cycles 0–4, high cycle 5.
- Read ADDRESS=1024 against an SRAM model holding the previous write → READ_DATA=0xDEADBEEF in cycle 5; WE_N=1 and DQ_OE=0 throughout.
- RD_EN=WR_EN=1 at ADDRESS=1028, data 0x12345678 → SRAM addresses 2 and 3 are written, READ_DATA is unchanged. A back-to-back read of 1028 starts one cycle after DONE and returns 0x12345678.
- ADDRESS=1020 → W=0x1FFFF; SRAM_ADDR 0x3FFFE then 0x3FFFF.
- ACCESS_CYCLES=1: read latency 4 cycles.
- RST pulsed low during HIGH → outputs immediately return to reset values.

Source files
------------

// File: rtl/sram_controller.sv
// Two-phase 16-bit SRAM access engine serving 32-bit MEM-stage loads/stores.
// READY low freezes the pipeline while a transaction is in flight.
module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RD_EN,
  input  logic        WR_EN,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        READY,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_WE_N
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST_PHASE = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic        is_wr_q, is_wr_d;
  logic [16:0] word_q, word_d;
  logic [15:0] wd_hi_q, wd_hi_d;
  logic [15:0] rd_lo_q, rd_lo_d;
  logic [31:0] read_data_q, read_data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        we_n_q, we_n_d;

  logic [31:0] offset;
  logic [16:0] word;
  logic        unused_offset_bits;

  assign offset             = ADDRESS - BASE_ADDR;
  assign word               = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    is_wr_d     = is_wr_q;
    word_d      = word_q;
    wd_hi_d     = wd_hi_q;
    rd_lo_d     = rd_lo_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    we_n_d      = we_n_q;
    case (state_q)
      S_IDLE: begin
        if (RD_EN || WR_EN) begin
          // Bus outputs for the low half are loaded on the same edge that enters LOW.
          state_d     = S_LOW;
          phase_d     = '0;
          is_wr_d     = WR_EN;
          word_d      = word;
          wd_hi_d     = WRITE_DATA[31:16];
          sram_addr_d = {word, 1'b0};
          dq_out_d    = WRITE_DATA[15:0];
          dq_oe_d     = WR_EN;
          we_n_d      = ~WR_EN;
        end
      end
      S_LOW: begin
        if (phase_q == LAST_PHASE) begin
          state_d     = S_HIGH;
          phase_d     = '0;
          rd_lo_d     = SRAM_DQ_IN;
          sram_addr_d = {word_q, 1'b1};
          dq_out_d    = wd_hi_q;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (phase_q == LAST_PHASE) begin
          state_d = S_DONE;
          phase_d = '0;
          dq_oe_d = 1'b0;
          we_n_d  = 1'b1;
          if (!is_wr_q) read_data_d = {SRAM_DQ_IN, rd_lo_q};
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wd_hi_q     <= '0;
      rd_lo_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      is_wr_q     <= is_wr_d;
      word_q      <= word_d;
      wd_hi_q     <= wd_hi_d;
      rd_lo_q     <= rd_lo_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign READY       = ((state_q == S_IDLE) && !RD_EN && !WR_EN) || (state_q == S_DONE);
  assign READ_DATA   = read_data_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_DQ_OUT = dq_out_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_WE_N   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: driver pushes expected transactions,
// a negedge monitor pops them when READY rises and checks data, latency and bus.
module tb_sram_controller;

  localparam int unsigned AC   = 2;
  localparam logic [31:0] BASE = 32'd1024;

  typedef struct {
    int          start;
    bit          wr;
    logic [16:0] w;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } txn_t;

  logic        clk, rst, rd_en, wr_en, ready, sram_dq_oe, sram_we_n;
  logic [31:0] address, write_data, read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic        r1_rd, r1_wr, r1_ready, r1_oe, r1_we_n;
  logic [31:0] r1_addr_in, r1_wdata, r1_rdata;
  logic [17:0] r1_addr;
  logic [15:0] r1_unused_dq, r1_dq_in;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   busy = 0;
  txn_t sb[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = '0;
  logic [15:0] sram [0:262143];

  sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(BASE)) dut (
    .CLK(clk), .RST(rst), .RD_EN(rd_en), .WR_EN(wr_en), .ADDRESS(address),
    .WRITE_DATA(write_data), .READ_DATA(read_data), .READY(ready),
    .SRAM_ADDR(sram_addr), .SRAM_DQ_OUT(sram_dq_out), .SRAM_DQ_IN(sram_dq_in),
    .SRAM_DQ_OE(sram_dq_oe), .SRAM_WE_N(sram_we_n)
  );

  sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
    .CLK(clk), .RST(rst), .RD_EN(r1_rd), .WR_EN(r1_wr), .ADDRESS(r1_addr_in),
    .WRITE_DATA(r1_wdata), .READ_DATA(r1_rdata), .READY(r1_ready),
    .SRAM_ADDR(r1_addr), .SRAM_DQ_OUT(r1_unused_dq), .SRAM_DQ_IN(r1_dq_in),
    .SRAM_DQ_OE(r1_oe), .SRAM_WE_N(r1_we_n)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model
  initial for (int i = 0; i < 262144; i++) sram[i] = '0;
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram[sram_addr];
  assign r1_dq_in   = r1_addr[15:0] ^ 16'h5A5A;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Issue one request at the current posedge+1; returns at posedge+1 after DONE.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit drop);
    txn_t t;
    int   n;
    t.start = cyc;
    t.wr    = wr;
    t.w     = 17'(((addr - BASE) >> 2) & 32'h1FFFF);
    t.wdata = data;
    if (wr) begin
      t.exp_rd = last_rd;
      ref_mem[int'(t.w)] = data;
    end else begin
      t.exp_rd = ref_mem.exists(int'(t.w)) ? ref_mem[int'(t.w)] : 32'h0;
      last_rd  = t.exp_rd;
    end
    sb.push_back(t);
    busy       = 1;
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = data;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (drop) begin rd_en = 0; wr_en = 0; end
    end
    rd_en = 0;
    wr_en = 0;
    if (busy) begin
      errors++;
      $display("FAIL timeout: READY never returned for address 0x%08h", addr);
      finish_run();
    end
  endtask

  // Monitor: per-cycle bus expectations derived from the transaction, final check on READY.
  initial begin
    int          bus_bad;
    int          k;
    txn_t        t;
    logic [17:0] a_lo, a_hi;
    bus_bad = 0;
    forever begin
      @(negedge clk);
      if (busy && rst) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: DUT busy with empty queue");
          busy = 0;
        end else begin
          t    = sb[0];
          k    = cyc - t.start;
          a_lo = 18'(t.w) * 18'd2;
          a_hi = a_lo + 18'd1;
          if (k == 0 || k == int'(2 * AC + 1)) begin
            if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) bus_bad++;
            if (k != 0 && sram_addr !== a_hi) bus_bad++;
          end else if (k >= 1 && k <= int'(2 * AC)) begin
            if (sram_addr !== ((k <= int'(AC)) ? a_lo : a_hi)) bus_bad++;
            if (sram_we_n !== !t.wr || sram_dq_oe !== t.wr) bus_bad++;
            if (t.wr && sram_dq_out !== ((k <= int'(AC)) ? t.wdata[15:0] : t.wdata[31:16])) bus_bad++;
          end
          if (ready) begin
            chk("latency", 32'(k), 32'(2 * AC + 1));
            chk("read_data", read_data, t.exp_rd);
            chk("bus_errors", 32'(bus_bad), 32'd0);
            bus_bad = 0;
            void'(sb.pop_front());
            busy = 0;
          end
        end
      end
    end
  end

  initial begin
    int          k;
    int          bad;
    logic [16:0] w;
    logic [31:0] a, d, e;
    rst = 0; rd_en = 1; wr_en = 0; address = '0; write_data = '0;
    r1_rd = 0; r1_wr = 0; r1_addr_in = '0; r1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    rd_en = 0;
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(ready), 32'h1);

    do_txn(0, 1, 32'd1024, 32'hDEADBEEF, 0);
    do_txn(1, 0, 32'd1024, 32'h0, 0);
    do_txn(1, 1, 32'd1028, 32'h12345678, 0);
    do_txn(1, 0, 32'd1028, 32'h0, 0);
    do_txn(0, 1, 32'd1020, 32'hCAFEF00D, 0);
    do_txn(1, 0, 32'd1020, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 15))
                                      : 17'(32'h1FFF0 + $urandom_range(0, 15));
      a = BASE + (32'(w) << 2) + 32'($urandom_range(0, 3)) + ($urandom << 19);
      d = $urandom;
      case ($urandom_range(0, 2))
        0:       do_txn(1, 0, a, d, $urandom_range(0, 3) == 0);
        1:       do_txn(0, 1, a, d, $urandom_range(0, 3) == 0);
        default: do_txn(1, 1, a, d, $urandom_range(0, 3) == 0);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset asserted while the HIGH half of a read is on the bus.
    @(posedge clk); #1;
    rd_en = 1; address = BASE + 32'd20;
    repeat (AC + 1) @(posedge clk);
    #1;
    chk("pre_reset_addr", 32'(sram_addr), 32'd11);
    rst = 0; rd_en = 0;
    #1;
    chk("midrst_read_data", read_data, 32'h0);
    chk("midrst_sram_addr", 32'(sram_addr), 32'h0);
    chk("midrst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("midrst_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("midrst_we_n", 32'(sram_we_n), 32'h1);
    chk("midrst_ready", 32'(ready), 32'h1);
    last_rd = '0;
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    do_txn(1, 0, 32'd1028, 32'h0, 0);

    // Single-cycle half-accesses: read latency of four cycles.
    @(posedge clk); #1;
    w = 17'h123;
    r1_addr_in = BASE + (32'(w) << 2);
    r1_rd = 1;
    bad = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (r1_we_n !== 1'b1 || r1_oe !== 1'b0) bad++;
      if (r1_ready) break;
      @(posedge clk); #1;
    end
    e = {(16'(w) * 16'd2 + 16'd1) ^ 16'h5A5A, (16'(w) * 16'd2) ^ 16'h5A5A};
    chk("ac1_latency", 32'(k + 1), 32'd4);
    chk("ac1_read_data", r1_rdata, e);
    chk("ac1_bus", 32'(bad), 32'd0);
    @(posedge clk); #1;
    r1_rd = 0;
    repeat (2) @(posedge clk);
    finish_run();
  end

endmodule
